maze_game_ctrl: RTL and testbench
=================================

# maze_game_ctrl

Game-sequencing controller for the maze display. It owns the screen-state FSM (welcome, map, win) and the current level. It also requests the level's maze bitmap from the map source and moves the player one block per key pulse after checking the target block in the map. Its registered outputs (`state`, `level`, `num`, `map`, `x_index`, `y_index`) drive the pixel renderer directly.

## Interface
Parameters:
- `LEVEL_MAX`, 5: highest level; levels are 0..LEVEL_MAX.
- `NUM_BASE`, 9: side length at level 0; `num` = NUM_BASE + 2*level. The maximum value must be ≤ 19.

Ports:
- `vga_clk` in 1: the single clock.
- `rst_sys_n` in 1: reset, synchronous, active-low.
- `key_start` in 1: one-cycle pulse, already debounced upstream.
- `key_up`, `key_down`, `key_left`, `key_right` in 1 each: one-cycle pulses, already debounced.
- `map_req` out 1: one-cycle pulse requesting the bitmap for `level`.
- `map_valid` in 1: one-cycle pulse from the map source; `map_in` is valid in that cycle.
- `map_in` in 361: bit (y*num + x) is 1 for road, 0 for wall.
- `map` out 361: latched bitmap, held stable between loads.
- `state` out 2: 0 = welcome, 1 = map, 2 = win. The value 3 is never driven.
- `level` out 3: current level.
- `num` out 5: blocks per side.
- `x_index`, `y_index` out 5 each: player block coordinates.
- `move_count` out 10: legal moves committed in the current level; saturates at 1023.

## Operation
Internal FSM states: S_WELCOME, S_LOAD, S_PLAY, S_CHECK, S_COMMIT, S_WIN.

Reset (rst_sys_n low at a vga_clk edge):
- FSM goes to S_WELCOME.
- `state`=0, `level`=0, `num`=NUM_BASE, `map`=0, `x_index`=`y_index`=1, `move_count`=0, `map_req`=0.

State behaviour:
- S_WELCOME: `key_start` → S_LOAD with `level`=0. Direction keys are ignored.
- S_LOAD:
  - `map_req` pulses in the first cycle of the state only.
  - The FSM waits in S_LOAD indefinitely for `map_valid`.
  - On `map_valid`: `map` ← `map_in`, `x_index`=`y_index`=1, `move_count`=0, then go to S_PLAY.
  - `state` holds its previous value (0 or 2) throughout S_LOAD, so the renderer never draws a stale map.
- S_PLAY: `state`=1. On any direction pulse, latch the target and go to S_CHECK.
  - Target: up is y−1, down is y+1, left is x−1, right is x+1.
  - If several direction pulses arrive in the same cycle, priority is up > down > left > right.
  - `key_start` is ignored in S_PLAY.
- S_CHECK: register index = ty*num + tx (9-bit) and an in-bounds flag. Next state is S_COMMIT.
  - A target is out of bounds if it is below 0 (detected as 5-bit underflow to 31) or ≥ `num`.
- S_COMMIT:
  - Legal move (in bounds and `map[index]`=1): update `x_index`/`y_index`; increment `move_count` (saturating).
    - If the new position is (num−2, num−2), go to S_WIN.
    - Otherwise go to S_PLAY.
  - Illegal move: position and count are unchanged; go to S_PLAY.
- S_WIN: `state`=2. Position and map are held.
  - `key_start` → S_LOAD with `level` incremented.
  - At LEVEL_MAX, `level` wraps to 0 instead, and the next state is S_WELCOME rather than S_LOAD.
- `num` is recomputed whenever `level` is written. It is registered and changes in the same cycle as `level`.

Ignored inputs:
- All key pulses arriving in S_CHECK, S_COMMIT or S_LOAD are dropped, not queued.
- A `map_valid` arriving outside S_LOAD is ignored.

## Timing
- Direction pulse in S_PLAY at edge t: the index is registered at t+1 and the position is committed at t+2. The next pulse is accepted from t+3.
- Win: `state`=2 is visible one edge after the commit that reaches the goal.
- `key_start` in S_WELCOME at t: S_LOAD is entered at t+1 and `map_req` is high during t+1..t+2.
  - If `map_valid` arrives at edge u, `state`=1 and the new map are visible at u+1.
- All outputs are registered; nothing is combinational from inputs to outputs.
- Reset mid-operation:
  - The FSM aborts to S_WELCOME at the next edge.
  - A map load in flight is abandoned; a late `map_valid` is ignored.

## Structure
- Package `maze_pkg` holds:
  - the state encodings (STATE_WELCOME=2'd0, STATE_MAP=2'd1, STATE_WIN=2'd2);
  - the internal FSM enum;
  - MAP_BITS=361;
  - the NUM_BASE and LEVEL_MAX defaults.
- One sub-module, `maze_move_check`, takes a direction, x/y, `num` and `map`. It returns the target coordinates, the registered index and the legal bit. It performs the S_CHECK/S_COMMIT datapath only.

## Test plan
- Reset, then `key_start`: `map_req` pulses once. Return `map_valid` 5 cycles later → `state`=1, `level`=0, `num`=9, `x_index`=`y_index`=1, `move_count`=0.
- Map with (2,1) road: pulse `key_right` → `x_index`=2 exactly 2 cycles later, `move_count`=1. A second pulse 1 cycle after the first is dropped.
- Wall at (1,0): `key_up` at (1,1) → position unchanged, `move_count`=0. Simultaneous `key_up`+`key_right` with (2,1) road → only the up move is evaluated, so there is no move.
- Road path to (7,7) at level 0: the final commit gives `state`=2. Then `key_start` → `level`=1, `num`=11, and a new `map_req`.
- Win at `level`=5 followed by `key_start` → `state`=0, `level`=0, `num`=9. A `map_valid` injected in S_PLAY leaves `map` unchanged.
- `rst_sys_n` low during S_LOAD → S_WELCOME at the next edge with all outputs at their reset values. A late `map_valid` is ignored.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared encodings and defaults for the maze game controller.
package maze_pkg;
   localparam int MAP_BITS      = 361;
   localparam int NUM_BASE_DEF  = 9;
   localparam int LEVEL_MAX_DEF = 5;

   localparam logic [1:0] STATE_WELCOME = 2'd0;
   localparam logic [1:0] STATE_MAP     = 2'd1;
   localparam logic [1:0] STATE_WIN     = 2'd2;

   typedef enum logic [2:0] {
      S_WELCOME, S_LOAD, S_PLAY, S_CHECK, S_COMMIT, S_WIN
   } fsm_t;

   typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

   function automatic logic [4:0] num_for_level(input logic [2:0] lvl, input int base);
      return 5'(base + 2 * int'(lvl));
   endfunction
endpackage

// File: rtl/maze_move_check.sv
// Move datapath: latches the target block, registers its map index and
// bounds flag, and reports whether the target is a reachable road block.
module maze_move_check
   import maze_pkg::*;
(
   input  logic                vga_clk,
   input  logic                rst_sys_n,
   input  logic                load_en,
   input  logic [1:0]          dir,
   input  logic                check_en,
   input  logic [4:0]          x,
   input  logic [4:0]          y,
   input  logic [4:0]          num,
   input  logic [MAP_BITS-1:0] map,
   output logic [4:0]          tx,
   output logic [4:0]          ty,
   output logic [8:0]          idx,
   output logic                legal
);
   logic in_bounds_q;

   always_ff @(posedge vga_clk) begin
      if (!rst_sys_n) begin
         tx          <= 5'd1;
         ty          <= 5'd1;
         idx         <= '0;
         in_bounds_q <= 1'b0;
      end else begin
         if (load_en) begin
            // Stepping below zero wraps to 31, which the bounds test rejects.
            case (dir)
               DIR_UP:    begin tx <= x;         ty <= y - 5'd1; end
               DIR_DOWN:  begin tx <= x;         ty <= y + 5'd1; end
               DIR_LEFT:  begin tx <= x - 5'd1;  ty <= y;        end
               default:   begin tx <= x + 5'd1;  ty <= y;        end
            endcase
         end
         if (check_en) begin
            idx         <= 9'(ty) * 9'(num) + 9'(tx);
            in_bounds_q <= (tx < num) && (ty < num);
         end
      end
   end

   assign legal = in_bounds_q && (idx < 9'(MAP_BITS)) && map[idx];
endmodule

// File: rtl/maze_game_ctrl.sv
// Maze game sequencer: screen state, level progression, map loading and
// player movement. All outputs are registered.
//
//   state     | meaning
//   S_WELCOME | title screen, waiting for key_start
//   S_LOAD    | map_req issued, waiting for map_valid
//   S_PLAY    | map shown, waiting for a direction pulse
//   S_CHECK   | target index and bounds being registered
//   S_COMMIT  | move applied if legal, goal test
//   S_WIN     | win screen, waiting for key_start
module maze_game_ctrl
   import maze_pkg::*;
#(
   parameter int LEVEL_MAX = LEVEL_MAX_DEF,
   parameter int NUM_BASE  = NUM_BASE_DEF
) (
   input  logic                vga_clk,
   input  logic                rst_sys_n,
   input  logic                key_start,
   input  logic                key_up,
   input  logic                key_down,
   input  logic                key_left,
   input  logic                key_right,
   output logic                map_req,
   input  logic                map_valid,
   input  logic [MAP_BITS-1:0] map_in,
   output logic [MAP_BITS-1:0] map,
   output logic [1:0]          state,
   output logic [2:0]          level,
   output logic [4:0]          num,
   output logic [4:0]          x_index,
   output logic [4:0]          y_index,
   output logic [9:0]          move_count
);
   fsm_t       fsm;
   dir_t       dir;
   logic       key_dir;
   logic [4:0] tx, ty;
   logic [8:0] idx;
   logic       legal;

   always_comb begin
      key_dir = key_up | key_down | key_left | key_right;
      dir     = DIR_RIGHT;
      if (key_up)        dir = DIR_UP;
      else if (key_down) dir = DIR_DOWN;
      else if (key_left) dir = DIR_LEFT;
   end

   maze_move_check u_move_check (
      .vga_clk   (vga_clk),
      .rst_sys_n (rst_sys_n),
      .load_en   ((fsm == S_PLAY) && key_dir),
      .dir       (dir),
      .check_en  (fsm == S_CHECK),
      .x         (x_index),
      .y         (y_index),
      .num       (num),
      .map       (map),
      .tx        (tx),
      .ty        (ty),
      .idx       (idx),
      .legal     (legal)
   );

   always_ff @(posedge vga_clk) begin
      if (!rst_sys_n) begin
         fsm        <= S_WELCOME;
         state      <= STATE_WELCOME;
         level      <= 3'd0;
         num        <= num_for_level(3'd0, NUM_BASE);
         map        <= '0;
         x_index    <= 5'd1;
         y_index    <= 5'd1;
         move_count <= 10'd0;
         map_req    <= 1'b0;
      end else begin
         map_req <= 1'b0;
         case (fsm)
            S_WELCOME: begin
               if (key_start) begin
                  fsm     <= S_LOAD;
                  level   <= 3'd0;
                  num     <= num_for_level(3'd0, NUM_BASE);
                  map_req <= 1'b1;
               end
            end
            S_LOAD: begin
               // state keeps the previous screen until the new map is in.
               if (map_valid) begin
                  map        <= map_in;
                  x_index    <= 5'd1;
                  y_index    <= 5'd1;
                  move_count <= 10'd0;
                  state      <= STATE_MAP;
                  fsm        <= S_PLAY;
               end
            end
            S_PLAY: begin
               if (key_dir) fsm <= S_CHECK;
            end
            S_CHECK: fsm <= S_COMMIT;
            S_COMMIT: begin
               fsm <= S_PLAY;
               if (legal) begin
                  x_index <= tx;
                  y_index <= ty;
                  if (move_count != 10'h3ff) move_count <= move_count + 10'd1;
                  if ((tx == num - 5'd2) && (ty == num - 5'd2)) begin
                     fsm   <= S_WIN;
                     state <= STATE_WIN;
                  end
               end
            end
            S_WIN: begin
               if (key_start) begin
                  if (level == 3'(LEVEL_MAX)) begin
                     level <= 3'd0;
                     num   <= num_for_level(3'd0, NUM_BASE);
                     state <= STATE_WELCOME;
                     fsm   <= S_WELCOME;
                  end else begin
                     level   <= level + 3'd1;
                     num     <= num_for_level(level + 3'd1, NUM_BASE);
                     map_req <= 1'b1;
                     fsm     <= S_LOAD;
                  end
               end
            end
            default: fsm <= S_WELCOME;
         endcase
      end
   end
endmodule

// File: tb/tb_maze_game_ctrl.sv
// Directed bench for maze_game_ctrl: table of moves on level 0 plus
// hand-written sequences for loading, level wrap and reset during load.
module tb_maze_game_ctrl;
   import maze_pkg::*;

   logic         vga_clk = 1'b0;
   logic         rst_sys_n = 1'b0;
   logic         key_start = 1'b0;
   logic         key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
   logic         map_req;
   logic         map_valid = 1'b0;
   logic [360:0] map_in = '0;
   logic [360:0] map;
   logic [1:0]   state;
   logic [2:0]   level;
   logic [4:0]   num, x_index, y_index;
   logic [9:0]   move_count;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] keys;   // {up, down, left, right}
      int ex, ey, ec, est;
   } vec_t;

   vec_t tbl[19];

   localparam logic [3:0] K_UP = 4'b1000, K_DOWN = 4'b0100,
                          K_LEFT = 4'b0010, K_RIGHT = 4'b0001;

   maze_game_ctrl dut (
      .vga_clk    (vga_clk),
      .rst_sys_n  (rst_sys_n),
      .key_start  (key_start),
      .key_up     (key_up),
      .key_down   (key_down),
      .key_left   (key_left),
      .key_right  (key_right),
      .map_req    (map_req),
      .map_valid  (map_valid),
      .map_in     (map_in),
      .map        (map),
      .state      (state),
      .level      (level),
      .num        (num),
      .x_index    (x_index),
      .y_index    (y_index),
      .move_count (move_count)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_map(input string name, input logic [360:0] exp);
      checks++;
      if (map !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, map, exp);
      end
   endtask

   function automatic logic [360:0] make_map(input int n);
      logic [360:0] m;
      m = '0;
      for (int x = 1; x <= n - 2; x++) m[n + x] = 1'b1;
      for (int y = 1; y <= n - 2; y++) m[y * n + (n - 2)] = 1'b1;
      return m;
   endfunction

   task automatic mv(input logic [3:0] k, input int ex, input int ey, input int ec,
                     input int est, input string name);
      {key_up, key_down, key_left, key_right} = k;
      tick();
      {key_up, key_down, key_left, key_right} = 4'b0000;
      tick();
      tick();
      chk({name, "_x"}, int'(x_index), ex);
      chk({name, "_y"}, int'(y_index), ey);
      chk({name, "_cnt"}, int'(move_count), ec);
      chk({name, "_state"}, int'(state), est);
   endtask

   task automatic start_load(input logic [360:0] m, input int lvl, input int n,
                             input int hold_state);
      key_start = 1'b1;
      tick();
      key_start = 1'b0;
      chk("load_req_high", int'(map_req), 1);
      chk("load_level", int'(level), lvl);
      chk("load_num", int'(num), n);
      chk("load_state_hold", int'(state), hold_state);
      tick();
      chk("load_req_low", int'(map_req), 0);
      tick(); tick(); tick();
      chk("load_wait_state", int'(state), hold_state);
      chk("load_wait_req", int'(map_req), 0);
      map_valid = 1'b1;
      map_in = m;
      tick();
      map_valid = 1'b0;
      chk("loaded_state", int'(state), 1);
      chk("loaded_x", int'(x_index), 1);
      chk("loaded_y", int'(y_index), 1);
      chk("loaded_cnt", int'(move_count), 0);
      chk_map("loaded_map", m);
   endtask

   task automatic run_level(input int lvl);
      int n;
      n = 9 + 2 * lvl;
      start_load(make_map(n), lvl, n, 2);
      for (int i = 0; i < n - 3; i++) mv(K_RIGHT, 2 + i, 1, i + 1, 1, "lvl_right");
      for (int i = 0; i < n - 3; i++)
         mv(K_DOWN, n - 2, 2 + i, n - 3 + i + 1, (i == n - 4) ? 2 : 1, "lvl_down");
   endtask

   initial begin
      logic [360:0] m0, m1;

      tbl[0] = '{K_UP,         2, 1, 1, 1};
      tbl[1] = '{K_LEFT,       1, 1, 2, 1};
      tbl[2] = '{K_UP,         1, 1, 2, 1};
      tbl[3] = '{K_LEFT,       1, 1, 2, 1};
      tbl[4] = '{K_UP | K_RIGHT, 1, 1, 2, 1};
      tbl[5] = '{K_DOWN,       1, 1, 2, 1};
      tbl[6] = '{K_RIGHT,      2, 1, 3, 1};
      for (int i = 0; i < 5; i++) tbl[7 + i] = '{K_RIGHT, 3 + i, 1, 4 + i, 1};
      tbl[12] = '{K_RIGHT,     7, 1, 8, 1};
      for (int i = 0; i < 6; i++) tbl[13 + i] = '{K_DOWN, 7, 2 + i, 9 + i, (i == 5) ? 2 : 1};

      m0 = make_map(9);
      m1 = make_map(11);
      m1[1]   = 1'b1;   // (1,0)
      m1[21]  = 1'b1;   // (10,1)
      m1[22]  = 1'b1;   // aliases (11,1)
      m1[342] = 1'b1;   // aliases (1,31)

      tick(); tick();
      chk("rst_state", int'(state), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_num", int'(num), 9);
      chk("rst_x", int'(x_index), 1);
      chk("rst_y", int'(y_index), 1);
      chk("rst_cnt", int'(move_count), 0);
      chk("rst_req", int'(map_req), 0);
      chk_map("rst_map", '0);
      rst_sys_n = 1'b1;
      tick();

      start_load(m0, 0, 9, 0);

      map_valid = 1'b1;
      map_in = '1;
      tick();
      map_valid = 1'b0;
      chk_map("play_map_valid_ignored", m0);
      chk("play_map_valid_state", int'(state), 1);

      key_right = 1'b1;
      tick();
      chk("right_t0_x", int'(x_index), 1);
      tick();
      key_right = 1'b0;
      chk("right_t1_x", int'(x_index), 1);
      tick();
      chk("right_t2_x", int'(x_index), 2);
      chk("right_t2_cnt", int'(move_count), 1);
      tick(); tick(); tick();
      chk("dropped_x", int'(x_index), 2);
      chk("dropped_cnt", int'(move_count), 1);

      for (int i = 0; i < 19; i++)
         mv(tbl[i].keys, tbl[i].ex, tbl[i].ey, tbl[i].ec, tbl[i].est, $sformatf("tbl%0d", i));

      mv(K_LEFT, 7, 7, 14, 2, "win_dir_ignored");

      start_load(m1, 1, 11, 2);
      mv(K_UP,   1, 0, 1, 1, "l1_up_edge");
      mv(K_UP,   1, 0, 1, 1, "l1_underflow");
      mv(K_DOWN, 1, 1, 2, 1, "l1_down");
      for (int i = 0; i < 8; i++) mv(K_RIGHT, 2 + i, 1, 3 + i, 1, "l1_right");
      mv(K_RIGHT, 10, 1, 11, 1, "l1_right_edge");
      mv(K_RIGHT, 10, 1, 11, 1, "l1_overflow");
      mv(K_LEFT,  9, 1, 12, 1, "l1_left");
      for (int i = 0; i < 8; i++) mv(K_DOWN, 9, 2 + i, 13 + i, (i == 7) ? 2 : 1, "l1_down");

      for (int l = 2; l <= 5; l++) run_level(l);

      key_start = 1'b1;
      tick();
      key_start = 1'b0;
      chk("wrap_state", int'(state), 0);
      chk("wrap_level", int'(level), 0);
      chk("wrap_num", int'(num), 9);
      chk("wrap_req", int'(map_req), 0);
      mv(K_RIGHT, 17, 17, 32, 0, "welcome_dir_ignored");

      key_start = 1'b1;
      tick();
      key_start = 1'b0;
      chk("midload_req", int'(map_req), 1);
      tick();
      rst_sys_n = 1'b0;
      tick();
      rst_sys_n = 1'b1;
      chk("midrst_state", int'(state), 0);
      chk("midrst_level", int'(level), 0);
      chk("midrst_num", int'(num), 9);
      chk("midrst_x", int'(x_index), 1);
      chk("midrst_y", int'(y_index), 1);
      chk("midrst_cnt", int'(move_count), 0);
      chk("midrst_req", int'(map_req), 0);
      chk_map("midrst_map", '0);
      map_valid = 1'b1;
      map_in = '1;
      tick();
      map_valid = 1'b0;
      tick();
      chk("late_valid_state", int'(state), 0);
      chk_map("late_valid_map", '0);

      start_load(m0, 0, 9, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
